// File: rtl/myadd_pipe_if.sv
// myadd_pipe_if: operand/result handshake bundle for the pipelined adder.
// The master side offers operands and takes results; the slave side is the adder.
interface myadd_pipe_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/myadd_pipe.sv
// myadd_pipe: pipelined N-bit adder/subtractor with valid/ready on both sides.
// The carry chain is cut into STAGES chunks of C = N/STAGES bits (N must be a
// multiple of STAGES). Each stage adds one chunk, appends it to the partial
// result it received and passes the still-unused upper operand bits forward,
// so register width shrinks on the operand side as it grows on the result side.
// Data registers only load on real beats: bubbles leave the previous contents
// in place, which keeps outputs at their reset value until the first result.
module myadd_pipe #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  myadd_pipe_if.slave    bus
);

  localparam int C = N / STAGES;

  logic         advance;
  logic [N-1:0] b_eff;
  logic         c0;
  logic         last_v;
  logic [N-1:0] last_sum;
  logic         last_cout;
  logic         ovf_d;
  logic         ovf_q;
  logic         zero_d;
  logic         zero_q;

  // Subtraction is a + ~b + ~cin, so cout=1 means "no borrow"
  always_comb begin
    b_eff = bus.sub ? ~bus.b   : bus.b;
    c0    = bus.sub ? ~bus.cin : bus.cin;
  end

  // The whole pipe moves together unless a finished result is waiting
  assign advance = !last_v || bus.out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : st
    localparam int SW = N - i * C;
    localparam int RW = (i + 1) * C;

    logic [SW-1:0] a_src;
    logic [SW-1:0] b_src;
    logic          c_src;
    logic          v_src;
    logic [C:0]    part;
    logic [RW-1:0] r_new;
    logic [RW-1:0] r_d;
    logic [RW-1:0] r_q;
    logic          c_d;
    logic          c_q;
    logic          v_d;
    logic          v_q;

    if (i == 0) begin : g_src
      assign a_src = bus.a;
      assign b_src = b_eff;
      assign c_src = c0;
      assign v_src = bus.in_valid;
      assign r_new = part[C-1:0];
    end else begin : g_src
      assign a_src = ops[i-1].a_q;
      assign b_src = ops[i-1].b_q;
      assign c_src = st[i-1].c_q;
      assign v_src = st[i-1].v_q;
      assign r_new = {part[C-1:0], st[i-1].r_q};
    end

    assign part = {1'b0, a_src[C-1:0]} + {1'b0, b_src[C-1:0]} + {{C{1'b0}}, c_src};

    // Shift the valid bit every advance; capture chunk result only for real beats
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      r_d = r_q;
      if (advance) begin
        v_d = v_src;
        if (v_src) begin
          c_d = part[C];
          r_d = r_new;
        end
      end
    end

    // Stage valid, carry and partial result registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        r_q <= r_d;
      end
    end
  end

  for (genvar i = 0; i < STAGES - 1; i++) begin : ops
    localparam int SW = N - i * C;
    localparam int OW = SW - C;

    logic [OW-1:0] a_d;
    logic [OW-1:0] a_q;
    logic [OW-1:0] b_d;
    logic [OW-1:0] b_q;

    // Carry the not-yet-added operand chunks alongside stage i's beat
    always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (advance && st[i].v_src) begin
        a_d = st[i].a_src[SW-1:C];
        b_d = st[i].b_src[SW-1:C];
      end
    end

    // Delayed upper operand registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  assign last_v    = st[STAGES-1].v_q;
  assign last_sum  = st[STAGES-1].r_q;
  assign last_cout = st[STAGES-1].c_q;

  // Overflow uses the operand msbs that reach the last stage; zero looks at the full result
  always_comb begin
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (advance && st[STAGES-1].v_src) begin
      ovf_d  = (st[STAGES-1].a_src[C-1] == st[STAGES-1].b_src[C-1]) &&
               (st[STAGES-1].part[C-1] != st[STAGES-1].a_src[C-1]);
      zero_d = (st[STAGES-1].r_new == '0);
    end
  end

  // Flag registers sit beside the final result so all outputs come from flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = last_v;
  assign bus.sum       = last_sum;
  assign bus.cout      = last_cout;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_myadd_pipe.sv
// tb_myadd_pipe: drives three adder configurations (8/2, 8/1, 16/4) from one
// clock. Every accepted operand beat is turned into an expected result by an
// integer-arithmetic model and queued; every delivered result is popped and
// compared. Directed steps on the 8/2 instance cover latency, flags, stall,
// bubbles and mid-stream reset; a random phase then streams all three.
module tb_myadd_pipe;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic        zero;
    logic [15:0] sum;
  } res_t;

  localparam int NB = 10000;

  logic clk;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  int          widths [3] = '{8, 8, 16};
  logic        in_valid_t  [3];
  logic [15:0] a_t         [3];
  logic [15:0] b_t         [3];
  logic        cin_t       [3];
  logic        sub_t       [3];
  logic        out_ready_t [3];

  logic        in_ready_o  [3];
  logic        out_valid_o [3];
  logic [15:0] sum_o       [3];
  logic        cout_o      [3];
  logic        ovf_o       [3];
  logic        zero_o      [3];

  logic        s_in_ready  [3];
  logic        s_out_valid [3];
  logic [15:0] s_sum       [3];
  logic        s_cout      [3];
  logic        s_ovf       [3];
  logic        s_zero      [3];

  res_t expq [3][$];
  int   acc  [3];

  myadd_pipe_if #(.N(8))  bus0 ();
  myadd_pipe_if #(.N(8))  bus1 ();
  myadd_pipe_if #(.N(16)) bus2 ();

  myadd_pipe #(.N(8),  .STAGES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  myadd_pipe #(.N(8),  .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  myadd_pipe #(.N(16), .STAGES(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.in_valid  = in_valid_t[0];
  assign bus0.a         = a_t[0][7:0];
  assign bus0.b         = b_t[0][7:0];
  assign bus0.cin       = cin_t[0];
  assign bus0.sub       = sub_t[0];
  assign bus0.out_ready = out_ready_t[0];
  assign bus1.in_valid  = in_valid_t[1];
  assign bus1.a         = a_t[1][7:0];
  assign bus1.b         = b_t[1][7:0];
  assign bus1.cin       = cin_t[1];
  assign bus1.sub       = sub_t[1];
  assign bus1.out_ready = out_ready_t[1];
  assign bus2.in_valid  = in_valid_t[2];
  assign bus2.a         = a_t[2];
  assign bus2.b         = b_t[2];
  assign bus2.cin       = cin_t[2];
  assign bus2.sub       = sub_t[2];
  assign bus2.out_ready = out_ready_t[2];

  assign in_ready_o[0]  = bus0.in_ready;
  assign out_valid_o[0] = bus0.out_valid;
  assign sum_o[0]       = {8'h00, bus0.sum};
  assign cout_o[0]      = bus0.cout;
  assign ovf_o[0]       = bus0.ovf;
  assign zero_o[0]      = bus0.zero;
  assign in_ready_o[1]  = bus1.in_ready;
  assign out_valid_o[1] = bus1.out_valid;
  assign sum_o[1]       = {8'h00, bus1.sum};
  assign cout_o[1]      = bus1.cout;
  assign ovf_o[1]       = bus1.ovf;
  assign zero_o[1]      = bus1.zero;
  assign in_ready_o[2]  = bus2.in_ready;
  assign out_valid_o[2] = bus2.out_valid;
  assign sum_o[2]       = bus2.sum;
  assign cout_o[2]      = bus2.cout;
  assign ovf_o[2]       = bus2.ovf;
  assign zero_o[2]      = bus2.zero;

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  function automatic logic [15:0] maskOf(input int k);
    return (widths[k] == 16) ? 16'hFFFF : 16'h00FF;
  endfunction

  // Expected result from plain integer arithmetic on unsigned and signed views
  function automatic res_t refModel(input int n, input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic sub);
    res_t   res;
    longint modv = longint'(1) << n;
    longint half = modv / 2;
    longint ua   = longint'(a);
    longint ub   = longint'(b);
    longint ci   = longint'(cin);
    longint sa   = (ua >= half) ? ua - modv : ua;
    longint sb   = (ub >= half) ? ub - modv : ub;
    longint r;
    longint sr;
    if (!sub) begin
      r        = ua + ub + ci;
      sr       = sa + sb + ci;
      res.cout = (r >= modv);
    end else begin
      r        = ua - ub - ci;
      sr       = sa - sb - ci;
      res.cout = (r >= 0);
    end
    res.sum  = 16'(r & (modv - 1));
    res.zero = ((r & (modv - 1)) == 0);
    res.ovf  = (sr < -half) || (sr >= half);
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub, input logic rdy);
    in_valid_t[k]  = v;
    a_t[k]         = a & maskOf(k);
    b_t[k]         = b & maskOf(k);
    cin_t[k]       = cin;
    sub_t[k]       = sub;
    out_ready_t[k] = rdy;
  endtask

  // Sample at the falling edge, score transfers due at the next rising edge, then step past it
  task automatic tick();
    res_t e;
    res_t o;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      s_in_ready[k]  = in_ready_o[k];
      s_out_valid[k] = out_valid_o[k];
      s_sum[k]       = sum_o[k];
      s_cout[k]      = cout_o[k];
      s_ovf[k]       = ovf_o[k];
      s_zero[k]      = zero_o[k];
      if (!rst && in_valid_t[k] && in_ready_o[k]) begin
        expq[k].push_back(refModel(widths[k], a_t[k], b_t[k], cin_t[k], sub_t[k]));
        acc[k]++;
      end
      if (!rst && out_valid_o[k] && out_ready_t[k]) begin
        checkOutput($sformatf("pending%0d", k), 32'(out_valid_o[k]), 32'(expq[k].size() != 0));
        if (expq[k].size() != 0) begin
          e      = expq[k].pop_front();
          o.ovf  = ovf_o[k];
          o.cout = cout_o[k];
          o.zero = zero_o[k];
          o.sum  = sum_o[k];
          checkOutput($sformatf("beat%0d", k), 32'(o), 32'(e));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One beat on the 8/2 instance, checking the two-cycle latency and the flags
  task automatic runSingle(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub,
                           input logic [7:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf, input logic exp_zero);
    applyStimulus(0, 1'b1, {8'h00, a}, {8'h00, b}, cin, sub, 1'b1);
    tick();
    checkOutput({tag, "_accept"}, 32'(s_in_ready[0]), 32'd1);
    applyStimulus(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput({tag, "_early"}, 32'(s_out_valid[0]), 32'd0);
    tick();
    checkOutput({tag, "_valid"}, 32'(s_out_valid[0]), 32'd1);
    checkOutput({tag, "_sum"},   32'(s_sum[0]),       32'(exp_sum));
    checkOutput({tag, "_cout"},  32'(s_cout[0]),      32'(exp_cout));
    checkOutput({tag, "_ovf"},   32'(s_ovf[0]),       32'(exp_ovf));
    checkOutput({tag, "_zero"},  32'(s_zero[0]),      32'(exp_zero));
  endtask

  function automatic logic [15:0] pickOp(input int k);
    int sel = int'($urandom_range(0, 7));
    logic [15:0] m = maskOf(k);
    case (sel)
      0:       return 16'h0000;
      1:       return m;
      2:       return (widths[k] == 16) ? 16'h8000 : 16'h0080;
      default: return 16'($urandom) & m;
    endcase
  endfunction

  // Directed steps followed by the random stream
  initial begin
    logic [7:0] t4a [4];
    logic [7:0] t4b [4];
    logic       t4c [4];
    logic       t4s [4];
    logic       exp_rdy [6];
    logic       pat [5];
    logic       ovh [8];
    int         idx;
    int         cyc;

    t4a     = '{8'h10, 8'hF0, 8'h33, 8'h7F};
    t4b     = '{8'h20, 8'h0F, 8'h44, 8'h01};
    t4c     = '{1'b0, 1'b1, 1'b0, 1'b0};
    t4s     = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pat     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    clk = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      acc[k] = 0;
    end
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_out_valid%0d", k), 32'(out_valid_o[k]), 32'd0);
      checkOutput($sformatf("rst_sum%0d", k),       32'(sum_o[k]),       32'd0);
      checkOutput($sformatf("rst_cout%0d", k),      32'(cout_o[k]),      32'd0);
      checkOutput($sformatf("rst_ovf%0d", k),       32'(ovf_o[k]),       32'd0);
      checkOutput($sformatf("rst_zero%0d", k),      32'(zero_o[k]),      32'd0);
      checkOutput($sformatf("rst_in_ready%0d", k),  32'(in_ready_o[k]),  32'd1);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed add/sub beats");
    runSingle("t2_add", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    runSingle("t3_sub_a", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    runSingle("t3_sub_b", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0);

    $display("[TB] stall with four beats");
    idx = 0;
    for (int c = 0; c < 20 && (idx < 4 || expq[0].size() != 0); c++) begin
      if (idx < 4)
        applyStimulus(0, 1'b1, {8'h00, t4a[idx]}, {8'h00, t4b[idx]}, t4c[idx], t4s[idx], c >= 5);
      else
        applyStimulus(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      tick();
      if (c < 6)
        checkOutput($sformatf("t4_in_ready_c%0d", c), 32'(s_in_ready[0]), 32'(exp_rdy[c]));
      if (c >= 2 && c <= 4) begin
        checkOutput($sformatf("t4_stall_valid_c%0d", c), 32'(s_out_valid[0]), 32'd1);
        checkOutput($sformatf("t4_stall_sum_c%0d", c),   32'(s_sum[0]),       32'h30);
        checkOutput($sformatf("t4_stall_cout_c%0d", c),  32'(s_cout[0]),      32'd0);
      end
      if (s_in_ready[0] && in_valid_t[0]) idx++;
    end
    checkOutput("t4_beats_in", 32'(idx), 32'd4);
    checkOutput("t4_drained", 32'(expq[0].size()), 32'd0);

    $display("[TB] bubble pattern");
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, (c < 5) ? pat[c] : 1'b0, 16'($urandom), 16'($urandom),
                    1'($urandom), 1'($urandom), 1'b1);
      tick();
      ovh[c] = s_out_valid[0];
    end
    for (int c = 2; c < 8; c++)
      checkOutput($sformatf("t5_out_valid_c%0d", c), 32'(ovh[c]), 32'((c - 2 < 5) ? pat[c - 2] : 1'b0));

    $display("[TB] reset with beats in flight");
    applyStimulus(0, 1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 16'h0033, 16'h0044, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_before_valid", 32'(out_valid_o[0]), 32'd1);
    #2 rst = 1'b1;
    for (int k = 0; k < 3; k++) expq[k].delete();
    #1;
    checkOutput("t1_out_valid", 32'(out_valid_o[0]), 32'd0);
    checkOutput("t1_sum",       32'(sum_o[0]),       32'd0);
    checkOutput("t1_in_ready",  32'(in_ready_o[0]),  32'd1);
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput($sformatf("t1_no_ghost_c%0d", c), 32'(s_out_valid[0]), 32'd0);
      checkOutput($sformatf("t1_sum_c%0d", c),      32'(s_sum[0]),       32'd0);
    end

    $display("[TB] random streams on all three configurations");
    for (int k = 0; k < 3; k++) acc[k] = 0;
    cyc = 0;
    while ((acc[0] < NB || acc[1] < NB || acc[2] < NB ||
            expq[0].size() != 0 || expq[1].size() != 0 || expq[2].size() != 0) && cyc < 60000) begin
      for (int k = 0; k < 3; k++)
        applyStimulus(k, (acc[k] < NB) ? ($urandom_range(0, 3) != 0) : 1'b0,
                      pickOp(k), pickOp(k), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t6_accepted%0d", k), 32'(acc[k] >= NB), 32'd1);
      checkOutput($sformatf("t6_drained%0d", k),  32'(expq[k].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
